// File: rtl/sram_avalon_responder.sv
// Avalon-MM word slave for the DE2 asynchronous 16-bit SRAM.
// One transfer at a time; strobe widths are set by READ_WAIT and WRITE_WAIT.
module sram_avalon_responder #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [17:0] av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [15:0] av_writedata,
  input  logic [1:0]  av_byteenable,
  output logic [15:0] av_readdata,
  output logic        av_readdatavalid,
  output logic        av_waitrequest,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [17:0]   r_addr, w_addr_nxt;
  logic [15:0]   r_wdata, w_wdata_nxt;
  logic [15:0]   r_rdata, w_rdata_nxt;
  logic          r_rvalid, w_rvalid_nxt;
  logic          r_ce_n, w_ce_n_nxt;
  logic          r_oe_n, w_oe_n_nxt;
  logic          r_we_n, w_we_n_nxt;
  logic          r_ub_n, w_ub_n_nxt;
  logic          r_lb_n, w_lb_n_nxt;
  logic          w_dq_oe;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_lb_n   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata  <= w_rdata_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_ce_n   <= w_ce_n_nxt;
      r_oe_n   <= w_oe_n_nxt;
      r_we_n   <= w_we_n_nxt;
      r_ub_n   <= w_ub_n_nxt;
      r_lb_n   <= w_lb_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata_nxt  = r_rdata;
    w_rvalid_nxt = 1'b0;
    w_ce_n_nxt   = r_ce_n;
    w_oe_n_nxt   = r_oe_n;
    w_we_n_nxt   = r_we_n;
    w_ub_n_nxt   = r_ub_n;
    w_lb_n_nxt   = r_lb_n;
    unique case (r_state)
      StIdle: begin
        // A simultaneous read and write resolves to the write; the read is dropped.
        if (av_write) begin
          w_state_nxt = StWrSetup;
          w_addr_nxt  = av_address;
          w_wdata_nxt = av_writedata;
          w_ce_n_nxt  = 1'b0;
          w_oe_n_nxt  = 1'b1;
          w_we_n_nxt  = 1'b1;
          w_ub_n_nxt  = ~av_byteenable[1];
          w_lb_n_nxt  = ~av_byteenable[0];
        end else if (av_read) begin
          w_state_nxt = StRd;
          w_addr_nxt  = av_address;
          w_cnt_nxt   = CW'(READ_WAIT - 1);
          w_ce_n_nxt  = 1'b0;
          w_oe_n_nxt  = 1'b0;
          w_we_n_nxt  = 1'b1;
          w_ub_n_nxt  = ~av_byteenable[1];
          w_lb_n_nxt  = ~av_byteenable[0];
        end
      end
      StRd: begin
        if (r_cnt == '0) begin
          w_state_nxt  = StIdle;
          w_rdata_nxt  = SRAM_DQ;
          w_rvalid_nxt = 1'b1;
          w_ce_n_nxt   = 1'b1;
          w_oe_n_nxt   = 1'b1;
          w_ub_n_nxt   = 1'b1;
          w_lb_n_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      StWrSetup: begin
        w_state_nxt = StWrPulse;
        w_cnt_nxt   = CW'(WRITE_WAIT - 1);
        w_we_n_nxt  = 1'b0;
      end
      StWrPulse: begin
        if (r_cnt == '0) begin
          w_state_nxt = StWrHold;
          w_we_n_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      StWrHold: begin
        w_state_nxt = StIdle;
        w_ce_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_ub_n_nxt  = 1'b1;
        w_lb_n_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // DQ follows the state register so an async reset releases the bus immediately.
  assign w_dq_oe = (r_state == StWrSetup) || (r_state == StWrPulse) || (r_state == StWrHold);
  assign SRAM_DQ = w_dq_oe ? r_wdata : 16'hzzzz;

  assign av_waitrequest   = (r_state != StIdle);
  assign av_readdata      = r_rdata;
  assign av_readdatavalid = r_rvalid;
  assign SRAM_ADDR        = r_addr;
  assign SRAM_CE_N        = r_ce_n;
  assign SRAM_OE_N        = r_oe_n;
  assign SRAM_WE_N        = r_we_n;
  assign SRAM_UB_N        = r_ub_n;
  assign SRAM_LB_N        = r_lb_n;

endmodule

// File: tb/tb_sram_avalon_responder.sv
// Bench for sram_avalon_responder: SRAM pin model, transaction-level reference model with a
// per-cycle compare, and directed checks including a READ_WAIT=3/WRITE_WAIT=2 instance.
`timescale 1ns/1ps
module tb_sram_avalon_responder;

  localparam int RW = 2;
  localparam int WW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT
  logic [17:0] a_addr = '0;
  logic        a_rd = 1'b0, a_wr = 1'b0;
  logic [15:0] a_wd = '0;
  logic [1:0]  a_be = '0;
  logic [15:0] rdata;
  logic        rvalid, wreq;
  logic [17:0] s_addr;
  wire  [15:0] dq;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  sram_avalon_responder #(.READ_WAIT(RW), .WRITE_WAIT(WW)) u_dut (
    .CLOCK_50(clk), .reset_n(rst_n), .av_address(a_addr), .av_read(a_rd), .av_write(a_wr),
    .av_writedata(a_wd), .av_byteenable(a_be), .av_readdata(rdata), .av_readdatavalid(rvalid),
    .av_waitrequest(wreq), .SRAM_ADDR(s_addr), .SRAM_DQ(dq), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // SRAM pin model: drives on CE&OE with WE high, writes enabled lanes while WE is low
  logic [15:0] sram [0:63] = '{default: 16'h0000};
  logic [15:0] sram_rd;
  logic        sram_oe;
  always_comb sram_rd = sram[s_addr[5:0]];
  assign sram_oe = !ce_n && !oe_n && we_n;
  assign dq = sram_oe ? sram_rd : 16'hzzzz;
  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) sram[s_addr[5:0]][15:8] <= dq[15:8];
      if (!lb_n) sram[s_addr[5:0]][7:0]  <= dq[7:0];
    end
  end

  // second instance with longer wait states
  logic [17:0] b_addr = '0;
  logic        b_rd = 1'b0, b_wr = 1'b0;
  logic [15:0] b_wd = '0;
  logic [1:0]  b_be = '0;
  logic [15:0] rdata6;
  logic        rv6, wreq6;
  logic [17:0] s_addr6;
  wire  [15:0] dq6;
  logic        ce6, oe6, we6, ub6, lb6;

  sram_avalon_responder #(.READ_WAIT(3), .WRITE_WAIT(2)) u_dut6 (
    .CLOCK_50(clk), .reset_n(rst_n), .av_address(b_addr), .av_read(b_rd), .av_write(b_wr),
    .av_writedata(b_wd), .av_byteenable(b_be), .av_readdata(rdata6), .av_readdatavalid(rv6),
    .av_waitrequest(wreq6), .SRAM_ADDR(s_addr6), .SRAM_DQ(dq6), .SRAM_CE_N(ce6),
    .SRAM_OE_N(oe6), .SRAM_WE_N(we6), .SRAM_UB_N(ub6), .SRAM_LB_N(lb6)
  );
  assign dq6 = (!ce6 && !oe6 && we6) ? 16'hC3A5 : 16'hzzzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: transaction timeline in cycle numbers
  int          busy_until = 0;
  int          acc_cyc = -100;
  int          rv_cyc = -100;
  bit          acc_wr = 1'b0;
  logic [17:0] acc_addr = '0;
  logic [15:0] acc_data = '0;
  logic [1:0]  acc_be = '0;
  logic [15:0] rv_data = '0;
  logic [15:0] exp_rdata = '0;
  logic [15:0] ref_mem [0:63] = '{default: 16'h0000};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_until = cyc;
      acc_cyc    = -100;
      rv_cyc     = -100;
      exp_rdata  = 16'h0000;
    end else begin
      if (cyc >= busy_until && (a_rd || a_wr)) begin
        acc_cyc  = cyc + 1;
        acc_wr   = a_wr;
        acc_addr = a_addr;
        acc_data = a_wd;
        acc_be   = a_be;
        busy_until = acc_cyc + (a_wr ? WW + 2 : RW);
        if (!a_wr) begin
          rv_cyc  = acc_cyc + RW;
          rv_data = ref_mem[a_addr[5:0]];
        end
      end
      // a write takes effect once its WE pulse has completed
      if (acc_wr && cyc + 1 == acc_cyc + 1 + WW) begin
        if (acc_be[1]) ref_mem[acc_addr[5:0]][15:8] = acc_data[15:8];
        if (acc_be[0]) ref_mem[acc_addr[5:0]][7:0]  = acc_data[7:0];
      end
      if (cyc + 1 == rv_cyc) exp_rdata = rv_data;
    end
  end

  always @(negedge clk) begin
    bit busy, rdb, wrb;
    busy = cyc < busy_until;
    rdb  = busy && !acc_wr;
    wrb  = busy && acc_wr;
    chk("waitrequest", wreq, busy);
    chk("readdatavalid", rvalid, cyc == rv_cyc);
    chk("readdata", rdata, exp_rdata);
    chk("ce_n", ce_n, !busy);
    chk("oe_n", oe_n, !rdb);
    chk("we_n", we_n, !(wrb && cyc >= acc_cyc + 1 && cyc <= acc_cyc + WW));
    chk("ub_n", ub_n, busy ? !acc_be[1] : 1'b1);
    chk("lb_n", lb_n, busy ? !acc_be[0] : 1'b1);
    if (busy) chk("sram_addr", s_addr, acc_addr);
    if (wrb) chk("dq_write", dq, acc_data);
    else if (rdb) chk("dq_read", dq, ref_mem[acc_addr[5:0]]);
    else begin
      total++;
      if (!(dq === 16'h0000 || $isunknown(dq))) begin
        bad++;
        $display("FAIL dq_idle cyc=%0d actual=%h required=released", cyc, dq);
      end
    end
  end

  // observation counters
  int          wq_cnt = 0, n_rv = 0, last_rv_cyc = -1000;
  logic [15:0] last_rv_data = '0;
  int          w6_cnt = 0, we6_cnt = 0, rv6_cyc = -1000;
  logic [15:0] rv6_data = '0;
  always @(negedge clk) begin
    if (wreq) wq_cnt++;
    if (rvalid) begin n_rv++; last_rv_cyc = cyc; last_rv_data = rdata; end
    if (wreq6) w6_cnt++;
    if (!we6) we6_cnt++;
    if (rv6) begin rv6_cyc = cyc; rv6_data = rdata6; end
  end

  // called at a negedge; returns at the negedge of the accept cycle
  task automatic issue(input bit rd, input bit wr, input logic [17:0] a, input logic [15:0] d,
                       input logic [1:0] be, output int acc);
    int n;
    n = 0;
    while (wreq && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("issue_timeout", 1, 0);
    a_rd = rd; a_wr = wr; a_addr = a; a_wd = d; a_be = be;
    @(negedge clk);
    acc = cyc;
    a_rd = 1'b0; a_wr = 1'b0;
    a_addr = 18'($urandom); a_wd = 16'($urandom); a_be = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (wreq && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, w0, r0, nr;
    logic [15:0] v;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    chk("reset_addr", s_addr, 18'h0);
    chk("reset_rdata", rdata, 16'h0);
    chk("reset_wreq", wreq, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write then read back, busy lengths and latency
    w0 = wq_cnt;
    issue(1'b0, 1'b1, 18'h00010, 16'hBEEF, 2'b11, acc);
    wait_idle();
    chk("t1_wr_busy", wq_cnt - w0, 3);
    w0 = wq_cnt;
    issue(1'b1, 1'b0, 18'h00010, 16'h0000, 2'b11, acc);
    wait_idle();
    chk("t1_rd_busy", wq_cnt - w0, 2);
    chk("t1_rd_latency", last_rv_cyc - acc, 2);
    chk("t1_rdata", last_rv_data, 16'hBEEF);

    // 2: byte-lane merge
    issue(1'b0, 1'b1, 18'd5, 16'h1234, 2'b11, acc);
    issue(1'b0, 1'b1, 18'd5, 16'hAB00, 2'b10, acc);
    chk("t2_lanes", {ub_n, lb_n}, 2'b01);
    issue(1'b1, 1'b0, 18'd5, 16'h0000, 2'b11, acc);
    wait_idle();
    chk("t2_rdata", last_rv_data, 16'hAB34);
    chk("t2_model_pin", ref_mem[5], 16'hAB34);

    // 3: read and write together, write wins
    r0 = n_rv;
    issue(1'b1, 1'b1, 18'd7, 16'h5555, 2'b11, acc);
    wait_idle();
    chk("t3_no_rvalid", n_rv - r0, 0);
    issue(1'b1, 1'b0, 18'd7, 16'h0000, 2'b11, acc);
    wait_idle();
    chk("t3_rdata", last_rv_data, 16'h5555);

    // 4: reset during the WE pulse
    r0 = n_rv;
    issue(1'b0, 1'b1, 18'd9, 16'hFFFF, 2'b11, acc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    chk("t4_wreq", wreq, 1'b0);
    total++;
    if (!(dq === 16'h0000 || $isunknown(dq))) begin
      bad++;
      $display("FAIL t4_dq_release actual=%h required=released", dq);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 18'd9, 16'h0000, 2'b11, acc);
    wait_idle();
    v = last_rv_data;
    total++;
    if (!(v === 16'h0000 || v === 16'hFFFF)) begin
      bad++;
      $display("FAIL t4_rdata actual=%h required=0000_or_ffff", v);
    end
    chk("t4_one_rvalid", n_rv - r0, 1);

    // 5: 100 alternating back-to-back transfers
    r0 = n_rv;
    nr = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0)
        issue(1'b0, 1'b1, 18'($urandom_range(0, 63)), 16'($urandom), 2'($urandom), acc);
      else begin
        issue(1'b1, 1'b0, 18'($urandom_range(0, 63)), 16'h0000, 2'b11, acc);
        nr++;
      end
    end
    wait_idle();
    chk("t5_rvalid_count", n_rv - r0, nr);

    // 6: READ_WAIT=3, WRITE_WAIT=2 instance
    w0 = w6_cnt;
    r0 = we6_cnt;
    b_wr = 1'b1; b_addr = 18'd3; b_wd = 16'h1111; b_be = 2'b11;
    @(negedge clk);
    b_wr = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_wr_busy", w6_cnt - w0, 4);
    chk("t6_we_low", we6_cnt - r0, 2);
    b_rd = 1'b1;
    @(negedge clk);
    acc = cyc;
    b_rd = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_rd_latency", rv6_cyc - acc, 3);
    chk("t6_rdata", rv6_data, 16'hC3A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
